radix2_butterfly_pipe: RTL and testbench
========================================

RADIX2_BUTTERFLY_PIPE -- requirements
Module: radix2_butterfly_pipe

Interface
REQ-001 SHALL have parameter DW, default 16: signed data width of A, B, X, Y components.
REQ-002 SHALL have parameter TW, default 16: signed twiddle width, format Q2.(TW-2), so 1.0 = 2^(TW-2).
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have ports ar, ai, br, bi, input, DW each: signed operands A and B.
REQ-006 SHALL have ports wr, wi, input, TW each: signed twiddle W.
REQ-007 SHALL have port inv, input, 1: 1 selects inverse transform, using conj(W).
REQ-008 SHALL have port scale, input, 2: output right shift of 0, 1 or 2; a value of 3 is treated as 2.
REQ-009 SHALL have ports in_valid (input, 1) and in_ready (output, 1): input handshake.
REQ-010 SHALL have ports xr, xi, yr, yi, output, DW each: results X and Y.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake.
REQ-012 SHALL have port sat, output, 1: set when any of the four components of the current output saturated.

Function
REQ-013 SHALL capture inv and scale with each sample and carry them down the pipe with it.
REQ-014 SHALL compute Z = B*W on full-width products, DW+TW+1 bits, with no intermediate truncation.
REQ-015 With inv=1, SHALL compute Z = B*conj(W).
REQ-016 SHALL compute X = A*2^(TW-2) + Z and Y = A*2^(TW-2) - Z at width DW+TW+2.
REQ-017 SHALL shift X and Y right arithmetically by (TW-2+scale), rounding half-up: add 2^(TW-3+scale) before the shift.
REQ-018 SHALL clamp each component to [-2^(DW-1), 2^(DW-1)-1] and set sat for that sample if any component clamps.
REQ-019 SHALL have a latency of exactly 4 clk cycles from an accepted input to out_valid, when there is no backpressure.
REQ-020 SHALL accept one sample per cycle.
REQ-021 SHALL form the pipeline-advance enable as adv = !out_valid | out_ready.
REQ-022 SHALL drive in_ready = adv.
REQ-023 SHALL accept an input only when in_valid & in_ready are both high.
REQ-024 When adv=0, all stages, including the valid bits, SHALL hold.
REQ-025 SHALL hold outputs stable while out_valid=1 and out_ready=0.
REQ-026 SHALL propagate bubbles, i.e. in_valid=0, as invalid stages and SHALL NOT collapse them.
REQ-027 SHALL NOT let data in invalid stages affect sat or any counter.

Reset
REQ-028 While rst_n=0, SHALL clear all stage valid bits, out_valid, sat, xr, xi, yr, yi and sat_cnt asynchronously.
REQ-029 Reset mid-stream SHALL discard all in-flight samples, with no output after release.
REQ-030 After rst_n rises, in_ready SHALL be 1 on the first clk edge.

Configuration
REQ-031 With macro RADIX2_BUTTERFLY_SAT_CNT_EN defined, the block SHALL add output sat_cnt, 16 bits.
REQ-032 sat_cnt SHALL increment once per output handshake (out_valid & out_ready) carrying sat=1.
REQ-033 sat_cnt SHALL stick at 0xFFFF and SHALL clear only on reset.
REQ-034 Without RADIX2_BUTTERFLY_SAT_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification (DW=16, TW=16, 1.0=0x4000)
REQ-035 SHALL cover: A=(100,0), B=(50,0), W=(0x4000,0), scale=0, inv=0, out_ready=1 -> X=(150,0), Y=(50,0), sat=0, out_valid exactly 4 cycles after accept.
REQ-036 SHALL cover: A=0, B=(10,0), W=(0,-0x4000): inv=0 -> X=(0,-10), Y=(0,10); inv=1 -> X=(0,10), Y=(0,-10).
REQ-037 SHALL cover: A=B=(32767,0), W=1.0: scale=0 -> Xr=32767, sat=1, Yr=0; scale=1 -> Xr=32767, sat=0; A=B=(-32768,0), scale=0 -> Xr=-32768, sat=1.
REQ-038 SHALL cover: A=(1,-1), B=0, scale=1 -> X=(1,0), Y=(1,0) (half-up rounding).
REQ-039 SHALL cover: stream 8 samples back-to-back, out_ready low for 3 cycles mid-stream -> in_ready low those cycles, no loss or duplication, output order preserved, outputs stable while stalled.
REQ-040 SHALL cover: assert rst_n=0 with 3 samples in flight -> out_valid=0 immediately; with the macro defined, sat_cnt=0 after reset and 2 after two saturating outputs.

Source files
------------

// File: rtl/radix2_butterfly_pipe.sv
// Radix-2 DIT butterfly, 4-stage valid/ready pipeline, rounding + saturation.
// Ports: clk, rst_n, ar/ai/br/bi, wr/wi, inv, scale, in_valid/in_ready,
//        xr/xi/yr/yi, sat, out_valid/out_ready; sat_cnt when
//        RADIX2_BUTTERFLY_SAT_CNT_EN is defined.
module radix2_butterfly_pipe #(
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] ar,
    input  logic [DW-1:0] ai,
    input  logic [DW-1:0] br,
    input  logic [DW-1:0] bi,
    input  logic [TW-1:0] wr,
    input  logic [TW-1:0] wi,
    input  logic          inv,
    input  logic [1:0]    scale,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] xr,
    output logic [DW-1:0] xi,
    output logic [DW-1:0] yr,
    output logic [DW-1:0] yi,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          sat
`ifdef RADIX2_BUTTERFLY_SAT_CNT_EN
   ,output logic [15:0]   sat_cnt
`endif
);

    localparam int PW = DW + TW;
    localparam int ZW = DW + TW + 1;
    localparam int XW = DW + TW + 2;

    localparam logic signed [XW-1:0] MAXV =
        {{(XW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [XW-1:0] MINV =
        {{(XW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic adv;
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    // stage 1: operand capture
    logic          s1_v;
    logic [DW-1:0] s1_ar, s1_ai, s1_br, s1_bi;
    logic [TW-1:0] s1_wr, s1_wi;
    logic          s1_inv;
    logic [1:0]    s1_sc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_ar  <= '0;
            s1_ai  <= '0;
            s1_br  <= '0;
            s1_bi  <= '0;
            s1_wr  <= '0;
            s1_wi  <= '0;
            s1_inv <= 1'b0;
            s1_sc  <= '0;
        end else if (adv) begin
            s1_v   <= in_valid;
            s1_ar  <= ar;
            s1_ai  <= ai;
            s1_br  <= br;
            s1_bi  <= bi;
            s1_wr  <= wr;
            s1_wi  <= wi;
            s1_inv <= inv;
            // shift of 3 is folded to 2 here so later stages see 0..2 only
            s1_sc  <= scale[1] ? 2'd2 : scale;
        end
    end

    // stage 2: four full-width partial products
    logic signed [PW-1:0] pa_c, pb_c, pc_c, pd_c;
    assign pa_c = PW'($signed(s1_br)) * PW'($signed(s1_wr));
    assign pb_c = PW'($signed(s1_bi)) * PW'($signed(s1_wi));
    assign pc_c = PW'($signed(s1_br)) * PW'($signed(s1_wi));
    assign pd_c = PW'($signed(s1_bi)) * PW'($signed(s1_wr));

    logic                 s2_v;
    logic signed [PW-1:0] s2_pa, s2_pb, s2_pc, s2_pd;
    logic [DW-1:0]        s2_ar, s2_ai;
    logic                 s2_inv;
    logic [1:0]           s2_sc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v   <= 1'b0;
            s2_pa  <= '0;
            s2_pb  <= '0;
            s2_pc  <= '0;
            s2_pd  <= '0;
            s2_ar  <= '0;
            s2_ai  <= '0;
            s2_inv <= 1'b0;
            s2_sc  <= '0;
        end else if (adv) begin
            s2_v   <= s1_v;
            s2_pa  <= pa_c;
            s2_pb  <= pb_c;
            s2_pc  <= pc_c;
            s2_pd  <= pd_c;
            s2_ar  <= s1_ar;
            s2_ai  <= s1_ai;
            s2_inv <= s1_inv;
            s2_sc  <= s1_sc;
        end
    end

    // stage 3: Z = B*W (or B*conj(W)), add/sub, round half-up, shift
    logic signed [ZW-1:0] zr, zi;
    logic signed [XW-1:0] axr, axi, rnd;
    logic signed [XW-1:0] xr_f, xi_f, yr_f, yi_f;
    logic signed [XW-1:0] xr_s, xi_s, yr_s, yi_s;
    int                   sh;

    always_comb begin
        zr = '0;
        zi = '0;
        if (s2_inv) begin
            zr = ZW'(s2_pa) + ZW'(s2_pb);
            zi = ZW'(s2_pd) - ZW'(s2_pc);
        end else begin
            zr = ZW'(s2_pa) - ZW'(s2_pb);
            zi = ZW'(s2_pc) + ZW'(s2_pd);
        end
        axr  = XW'($signed(s2_ar)) <<< (TW - 2);
        axi  = XW'($signed(s2_ai)) <<< (TW - 2);
        xr_f = axr + XW'(zr);
        xi_f = axi + XW'(zi);
        yr_f = axr - XW'(zr);
        yi_f = axi - XW'(zi);
        sh   = TW - 2 + int'(s2_sc);
        rnd  = XW'(1) <<< (sh - 1);
        xr_s = (xr_f + rnd) >>> sh;
        xi_s = (xi_f + rnd) >>> sh;
        yr_s = (yr_f + rnd) >>> sh;
        yi_s = (yi_f + rnd) >>> sh;
    end

    logic                 s3_v;
    logic signed [XW-1:0] s3_xr, s3_xi, s3_yr, s3_yi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_v  <= 1'b0;
            s3_xr <= '0;
            s3_xi <= '0;
            s3_yr <= '0;
            s3_yi <= '0;
        end else if (adv) begin
            s3_v  <= s2_v;
            s3_xr <= xr_s;
            s3_xi <= xi_s;
            s3_yr <= yr_s;
            s3_yi <= yi_s;
        end
    end

    // stage 4: clamp to DW bits and register outputs
    function automatic logic ovf(input logic signed [XW-1:0] v);
        return (v > MAXV) || (v < MINV);
    endfunction

    function automatic logic [DW-1:0] clip(input logic signed [XW-1:0] v);
        logic [DW-1:0] r;
        if (v > MAXV)      r = MAXV[DW-1:0];
        else if (v < MINV) r = MINV[DW-1:0];
        else               r = v[DW-1:0];
        return r;
    endfunction

    logic any_ovf;
    assign any_ovf = ovf(s3_xr) | ovf(s3_xi) | ovf(s3_yr) | ovf(s3_yi);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sat       <= 1'b0;
            xr        <= '0;
            xi        <= '0;
            yr        <= '0;
            yi        <= '0;
        end else if (adv) begin
            out_valid <= s3_v;
            // a bubble never reports saturation
            sat       <= s3_v & any_ovf;
            xr        <= clip(s3_xr);
            xi        <= clip(s3_xi);
            yr        <= clip(s3_yr);
            yi        <= clip(s3_yi);
        end
    end

`ifdef RADIX2_BUTTERFLY_SAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (out_valid && out_ready && sat && sat_cnt != 16'hFFFF) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_radix2_butterfly_pipe.sv
// Scoreboard bench for radix2_butterfly_pipe (DW=16, TW=16, 1.0 = 0x4000).
// Expected results are queued on input handshake and checked on output.
module tb_radix2_butterfly_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ar, ai, br, bi, wr, wi;
    logic        inv;
    logic [1:0]  scale;
    logic        in_valid, in_ready;
    logic [15:0] xr, xi, yr, yi;
    logic        out_valid, out_ready, sat;
`ifdef RADIX2_BUTTERFLY_SAT_CNT_EN
    logic [15:0] sat_cnt;
`endif

    always #5 clk = ~clk;

    radix2_butterfly_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .ar(ar), .ai(ai), .br(br), .bi(bi),
        .wr(wr), .wi(wi), .inv(inv), .scale(scale),
        .in_valid(in_valid), .in_ready(in_ready),
        .xr(xr), .xi(xi), .yr(yr), .yi(yi),
        .out_valid(out_valid), .out_ready(out_ready),
        .sat(sat)
`ifdef RADIX2_BUTTERFLY_SAT_CNT_EN
       ,.sat_cnt(sat_cnt)
`endif
    );

    typedef struct {
        longint xr, xi, yr, yi;
        logic   sat;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_pass = 0;
    logic acc;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic longint rnd_sh(input longint v, input int sh);
        longint half;
        half = longint'(1) <<< (sh - 1);
        return (v + half) >>> sh;
    endfunction

    function automatic longint clampv(input longint v, output logic s);
        s = 1'b0;
        if (v > 32767)  begin s = 1'b1; return 32767;  end
        if (v < -32768) begin s = 1'b1; return -32768; end
        return v;
    endfunction

    function automatic exp_t model();
        exp_t   e;
        longint a_r, a_i, b_r, b_i, w_r, w_i, z_r, z_i;
        int     sh;
        logic   s0, s1, s2, s3;
        a_r = longint'($signed(ar));
        a_i = longint'($signed(ai));
        b_r = longint'($signed(br));
        b_i = longint'($signed(bi));
        w_r = longint'($signed(wr));
        w_i = inv ? -longint'($signed(wi)) : longint'($signed(wi));
        z_r = b_r * w_r - b_i * w_i;
        z_i = b_r * w_i + b_i * w_r;
        sh  = 14 + ((scale == 2'd3) ? 2 : int'(scale));
        e.xr = clampv(rnd_sh(a_r * 16384 + z_r, sh), s0);
        e.xi = clampv(rnd_sh(a_i * 16384 + z_i, sh), s1);
        e.yr = clampv(rnd_sh(a_r * 16384 - z_r, sh), s2);
        e.yi = clampv(rnd_sh(a_i * 16384 - z_i, sh), s3);
        e.sat = s0 | s1 | s2 | s3;
        return e;
    endfunction

    task automatic set_in(input int a_r, input int a_i, input int b_r,
                          input int b_i, input int w_r, input int w_i,
                          input logic iv, input logic [1:0] sc);
        ar = 16'(a_r); ai = 16'(a_i);
        br = 16'(b_r); bi = 16'(b_i);
        wr = 16'(w_r); wi = 16'(w_i);
        inv = iv; scale = sc;
    endtask

    // one clock: drive at negedge, check/record handshakes, end at next negedge
    task automatic cyc(input logic iv, input logic ordy, output logic a);
        exp_t e;
        in_valid  = iv;
        out_ready = ordy;
        #1;
        chk("in_ready", in_ready, !out_valid || ordy);
        if (out_valid) begin
            if (sbq.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = sbq[0];
                chk("xr", $signed(xr), e.xr);
                chk("xi", $signed(xi), e.xi);
                chk("yr", $signed(yr), e.yr);
                chk("yi", $signed(yi), e.yi);
                chk("sat", sat, e.sat);
                if (ordy) void'(sbq.pop_front());
            end
        end
        a = iv && in_ready;
        if (a) sbq.push_back(model());
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sbq.size() != 0; i++) cyc(1'b0, 1'b1, acc);
        chk("drain", sbq.size(), 0);
    endtask

    task automatic send1(input int a_r, input int a_i, input int b_r,
                         input int b_i, input int w_r, input int w_i,
                         input logic iv, input logic [1:0] sc);
        set_in(a_r, a_i, b_r, b_i, w_r, w_i, iv, sc);
        cyc(1'b1, 1'b1, acc);
        drain();
    endtask

    int n;
    int idx;
    int c;

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 1'b0, 2'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sat", sat, 0);
        chk("rst_xr", xr, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", in_ready, 1);
        @(negedge clk);

        // latency: count edges from the accepting edge until out_valid
        set_in(100, 0, 50, 0, 16'h4000, 0, 1'b0, 2'd0);
        cyc(1'b1, 1'b1, acc);
        chk("accept", acc, 1);
        n = 1;
        while (n < 20) begin
            #1;
            if (out_valid) break;
            cyc(1'b0, 1'b1, acc);
            n++;
        end
        chk("latency", n, 4);
        drain();

        // twiddle -j, forward and inverse
        send1(0, 0, 10, 0, 0, -16384, 1'b0, 2'd0);
        send1(0, 0, 10, 0, 0, -16384, 1'b1, 2'd0);
        // saturation and scaling
        send1(32767, 0, 32767, 0, 16384, 0, 1'b0, 2'd0);
        send1(32767, 0, 32767, 0, 16384, 0, 1'b0, 2'd1);
        send1(-32768, 0, -32768, 0, 16384, 0, 1'b0, 2'd0);
        send1(-32768, 0, -32768, 0, 16384, 0, 1'b0, 2'd3);
        // half-up rounding
        send1(1, -1, 0, 0, 0, 0, 1'b0, 2'd1);
        // general complex twiddle
        send1(1234, -567, -890, 321, 11585, -11585, 1'b1, 2'd2);

        // 8 back-to-back samples with a 3-cycle output stall mid-stream
        idx = 0;
        c = 0;
        set_in(int'($urandom), int'($urandom), int'($urandom),
               int'($urandom), int'($urandom), int'($urandom),
               1'($urandom), 2'($urandom));
        while (idx < 8 && c < 40) begin
            cyc(1'b1, !(c >= 5 && c < 8), acc);
            if (c >= 5 && c < 8) chk("stall_ready", acc, 0);
            if (acc) begin
                idx++;
                set_in(int'($urandom), int'($urandom), int'($urandom),
                       int'($urandom), int'($urandom), int'($urandom),
                       1'($urandom), 2'($urandom));
            end
            c++;
        end
        chk("stream_sent", idx, 8);
        drain();

        // bubbles interleaved with data
        for (int i = 0; i < 6; i++) begin
            set_in(32767, 32767, 32767, -32768, 16384, 16384, 1'(i), 2'(i));
            cyc(1'(i % 2), 1'b1, acc);
        end
        drain();

        // reset with samples in flight
        for (int i = 0; i < 3; i++) begin
            set_in(100 * i, 7, 3, -4, 16384, 0, 1'b0, 2'd0);
            cyc(1'b1, 1'b1, acc);
        end
        cyc(1'b0, 1'b0, acc);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_sat", sat, 0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst2", in_ready, 1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, acc);

`ifdef RADIX2_BUTTERFLY_SAT_CNT_EN
        chk("sat_cnt_rst", sat_cnt, 0);
        set_in(32767, 0, 32767, 0, 16384, 0, 1'b0, 2'd0);
        cyc(1'b1, 1'b1, acc);
        cyc(1'b1, 1'b1, acc);
        set_in(10, 0, 10, 0, 16384, 0, 1'b0, 2'd0);
        cyc(1'b1, 1'b1, acc);
        drain();
        chk("sat_cnt_2", sat_cnt, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
